// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
// Module   : word_packer
// Purpose  : Collects a stream of Width-bit words into frames of Count words
//            and presents each frame as one packed Width*Count-bit word.
//            Valid/ready handshake on both sides. A separate output holding
//            register lets the next frame assemble while the current frame
//            waits for the consumer.
// Ports    : clk_i    - clock, rising edge
//            rst_ni   - asynchronous active-low reset
//            clear_i  - synchronous abort of the partially assembled frame
//            valid_i  - input word present on data_i
//            ready_o  - block accepts a word this cycle
//            data_i   - input word (Width bits)
//            valid_o  - packed frame present on data_o
//            ready_i  - consumer accepts the frame this cycle
//            data_o   - packed frame, first-accepted word in the LSBs
//            level_o  - words held in the partial frame (0..Count-1)
// Revision : 1.0 - initial release
// ============================================================================
module word_packer #(
    parameter int Width = 1,
    parameter int Count = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [Width-1:0]         data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [Width*Count-1:0]   data_o,
    output logic [$clog2(Count)-1:0] level_o
);

    localparam int CNT_W = $clog2(Count);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(Count - 1);

    // Assembly lanes; the final word of a frame bypasses them and goes
    // straight into the output register alongside the stored lanes.
    logic [Count-2:0][Width-1:0] r_lanes;
    logic [CNT_W-1:0]            r_cnt;
    logic [Width*Count-1:0]      r_data_out;
    logic                        r_valid_out;

    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_complete;
    logic w_consume;

    assign w_last     = (r_cnt == C_LAST);
    // Only backpressure case: the final word would overwrite a held frame
    // that the consumer is not draining this cycle.
    assign w_ready    = !clear_i && !(w_last && r_valid_out && !ready_i);
    assign w_accept   = valid_i && w_ready;
    assign w_complete = w_accept && w_last;
    assign w_consume  = r_valid_out && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lanes     <= '0;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            // Word counter / partial-frame bookkeeping
            if (clear_i) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // Lane loads; lanes are left stale once a frame completes
            for (int i = 0; i < Count - 1; i++) begin
                if (w_accept && !w_last && (r_cnt == CNT_W'(i))) begin
                    r_lanes[i] <= data_i;
                end
            end

            // Output register: a completing frame wins over a consume, so a
            // simultaneous consume+complete keeps valid high with new data.
            if (w_complete) begin
                r_data_out  <= {data_i, r_lanes};
                r_valid_out <= 1'b1;
            end else if (w_consume) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid_out;
    assign data_o  = r_data_out;
    assign level_o = r_cnt;

endmodule
`default_nettype wire

// File: doc/word_packer.md
# word_packer

Downstream companion to the team's shift register: collects a stream of `Width`-bit words (one per write strobe, as produced at a shift register's output) into frames of `Count` words and presents each frame as one packed `Width*Count`-bit word. It has a valid/ready handshake on both sides. A dedicated output holding register lets the next frame assemble while the current frame waits for the consumer.

## Interface
Parameters:
- `Width`, default 1: bits per input word; must be ≥1.
- `Count`, default 4: words per frame; must be ≥2.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous abort of the partially assembled frame.
- `valid_i`  in  1  input word present on `data_i`.
- `ready_o`  out  1  block can accept a word this cycle.
- `data_i`  in  `Width`  input word.
- `valid_o`  out  1  packed frame present on `data_o`.
- `ready_i`  in  1  consumer accepts the frame this cycle.
- `data_o`  out  `Width*Count`  packed frame; the first-accepted word is in bits `[Width-1:0]`, and word k is in bits `[k*Width +: Width]`.
- `level_o`  out  `$clog2(Count)`  number of words in the partial frame (0..Count-1).

## Operation
- State:
  - Assembly register: `Count-1` lanes of `Width` bits.
  - Word counter `cnt`, range 0..Count-1, driven on `level_o`.
  - Output register, which drives `data_o`.
  - Output valid flag, which drives `valid_o`.
- **Accept:** an input word is accepted when `valid_i && ready_o` at a rising edge.
- **Accept with `cnt < Count-1`:**
  - Lane `cnt` is loaded with `data_i`.
  - `cnt` increments.
- **Accept with `cnt == Count-1` (frame complete):**
  - The output register is loaded with `{data_i, lane[Count-2], ..., lane[0]}`.
  - `valid_o` is set to 1.
  - `cnt` returns to 0.
  - Assembly lanes keep stale contents; they are never observable.
- **Output consume:** occurs when `valid_o && ready_i`.
  - If no frame completes in the same cycle, `valid_o` clears to 0.
  - If a frame completes in the same cycle, `valid_o` stays 1 and `data_o` takes the new frame.
- **`ready_o`** is defined as `!clear_i && !(cnt == Count-1 && valid_o && !ready_i)`.
  - The only backpressure case is a final word arriving while the held frame is not being drained.
  - `ready_o` is combinational from `ready_i` and `clear_i`; the consumer must not make `ready_i` depend on `ready_o`.
- **`clear_i`:**
  - `cnt` goes to 0 at the next edge, and the partial frame is discarded.
  - No word is accepted in that cycle, since `ready_o` is forced low.
  - The output register and `valid_o` are unaffected; a consume in the same cycle proceeds normally.
- **Data stability:** while `valid_o && !ready_i`, `data_o` and `valid_o` are held stable.
- **Input with `ready_o` low:** `valid_i` is ignored; the upstream must hold its word.

## Timing
- **Reset values** (asserted on `rst_ni` low, immediately and independent of `clk_i`):
  - `cnt` / `level_o` = 0
  - `valid_o` = 0
  - `data_o` = 0
  - assembly lanes = 0
  - `ready_o` = 1, provided `clear_i` is low
- **Latency:** `valid_o` rises on the same edge that accepts the `Count`-th word of a frame, i.e. one cycle after that word is presented with `ready_o` high.
- **Throughput:** one word per cycle sustained, provided the consumer drains each frame within `Count-1` cycles of its appearance.
- **Reset mid-frame:** the partial frame and any held output are lost; after release, the next accepted word goes to lane 0.
- **Back-to-back frames with `ready_i` tied high:** `valid_o` pulses for exactly one cycle every `Count` accepted words.

## Test plan
Bench configuration for all scenarios: `Width`=4, `Count`=3.
1. **Reset:** drive `rst_ni` low mid-cycle with `cnt`=2 and `valid_o`=1 → immediately `valid_o`=0, `data_o`=0, `level_o`=0; after release, the words 0x1, 0x2, 0x3 produce `data_o`=0x321.
2. **Streaming:** `ready_i`=1 and `valid_i`=1 continuously, data 0x1..0x6 → `valid_o`=1 with 0x321 on the edge accepting 0x3, 0 for two cycles, then 1 with 0x654; `ready_o` stays 1 throughout.
3. **Backpressure:**
   - With `ready_i`=0, send 0x1..0x6 → after 0x3, `valid_o`=1 and `data_o`=0x321 holds.
   - 0x4 and 0x5 are accepted (`level_o`=2), then `ready_o`=0 while 0x6 is pending.
   - Raise `ready_i` → 0x6 is accepted that cycle and `data_o`=0x654 with `valid_o` still 1.
4. **Simultaneous consume and complete:** with `valid_o`=1 and `level_o`=2, drive `ready_i`=1 and `valid_i`=1 (data 0x9) in the same cycle → next cycle `valid_o`=1 with the new frame whose top nibble is 0x9; no frame is lost or duplicated.
5. **Clear:**
   - Accept 0xA, 0xB (`level_o`=2), then assert `clear_i` with `valid_i`=1 → `ready_o`=0 that cycle and `level_o`=0 next cycle; `valid_o` is unchanged.
   - Then send 0x1, 0x2, 0x3 → `data_o`=0x321.
6. **Idle gaps:** `valid_i` pulsed every third cycle with data 0x7, 0x8, 0x9 → `level_o` steps 1, 2, then `valid_o`=1 with `data_o`=0x987; `level_o` is unchanged during gaps.
